// File: rtl/key_filter_pkg.sv
// Shared LED/key project definitions: key FSM encodings and default timing constants.
package key_filter_pkg;

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned LCNT_W = 26;

  // 20 ms debounce and 1 s long-press at 50 MHz
  localparam logic [CNT_W-1:0]  FILTER_VAL_DEF = 20'd999_999;
  localparam logic [LCNT_W-1:0] LONG_VAL_DEF   = 26'd49_999_999;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic rst_val = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_filter.sv
// Debounced key with press pulse, pressed level and one-shot long-press pulse.
// Raw key is active-low; key_state is active-high.
module key_filter
  import key_filter_pkg::*;
#(
  parameter logic [CNT_W-1:0]  filter_val = FILTER_VAL_DEF,
  parameter logic [LCNT_W-1:0] long_val   = LONG_VAL_DEF
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state,
  output logic key_long
);

  logic              key_s;
  key_fsm_t          state;
  logic [CNT_W-1:0]  cnt;
  logic [LCNT_W-1:0] lcnt;
  logic              long_done;

  // Reset to released so reset itself never looks like a press
  sync_2ff #(.rst_val(1'b1)) u_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (key_s)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lcnt      <= '0;
      long_done <= 1'b0;
      key_flag  <= 1'b0;
      key_state <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_flag <= 1'b0;
      key_long <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_s) begin
            state <= PRESS_FILT;
            cnt   <= '0;
          end
        end
        PRESS_FILT: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == filter_val) begin
            state     <= DOWN;
            key_flag  <= 1'b1;
            key_state <= 1'b1;
            lcnt      <= '0;
            long_done <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DOWN: begin
          // long_done keeps the pulse one-shot while lcnt sits saturated
          if (lcnt == long_val && !long_done) begin
            key_long  <= 1'b1;
            long_done <= 1'b1;
          end
          if (key_s) begin
            state <= REL_FILT;
            cnt   <= '0;
          end else if (lcnt != long_val) begin
            lcnt <= lcnt + LCNT_W'(1);
          end
        end
        REL_FILT: begin
          if (!key_s) begin
            state <= DOWN;
          end else if (cnt == filter_val) begin
            state     <= IDLE;
            key_state <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          key_state <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with short debounce/long-press constants.
module tb_key_filter;
  import key_filter_pkg::*;

  localparam logic [CNT_W-1:0]  FV = 20'd10;
  localparam logic [LCNT_W-1:0] LV = 26'd50;

  logic sys_clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic key_flag;
  logic key_state;
  logic key_long;

  always #10 sys_clk = ~sys_clk;

  key_filter #(.filter_val(FV), .long_val(LV)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_state (key_state),
    .key_long  (key_long)
  );

  int checks = 0;
  int errors = 0;
  int n_flag = 0;
  int n_long = 0;
  logic prev_flag = 1'b0;
  logic prev_long = 1'b0;

  // Pulse counting plus the single-cycle / only-while-pressed pulse rules
  always @(posedge sys_clk) begin
    #1;
    if (rst_n) begin
      checks++;
      if ((key_flag && prev_flag) || (key_long && prev_long) ||
          ((key_flag || key_long) && !key_state)) begin
        errors++;
        $display("FAIL pulse_rule t=%0t flag=%b long=%b state=%b prev_flag=%b prev_long=%b (required: 1-cycle pulses, only with key_state=1)",
                 $time, key_flag, key_long, key_state, prev_flag, prev_long);
      end
    end
    if (key_flag) n_flag++;
    if (key_long) n_long++;
    prev_flag = key_flag;
    prev_long = key_long;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // sel 0: key_flag high, 1: key_long high, 2: key_state low; idx = 0-based edge index, -1 on timeout
  task automatic edges_until(input int sel, input int max_edges, output int idx);
    idx = -1;
    for (int i = 0; i < max_edges; i++) begin
      @(posedge sys_clk);
      #1;
      if ((sel == 0 && key_flag) || (sel == 1 && key_long) || (sel == 2 && !key_state)) begin
        idx = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic  key;
    int    cycles;
    int    flags;
    int    longs;
    logic  state;
    string name;
  } vec_t;

  vec_t vecs[$];
  int   idx;

  initial begin
    vecs.push_back('{1'b1, 20,  0, 0, 1'b0, "idle_high"});
    vecs.push_back('{1'b0,  5,  0, 0, 1'b0, "glitch_low"});
    vecs.push_back('{1'b1, 20,  0, 0, 1'b0, "glitch_after"});
    vecs.push_back('{1'b0, 20,  1, 0, 1'b1, "clean_press"});
    vecs.push_back('{1'b1, 20,  0, 0, 1'b0, "clean_release"});
    vecs.push_back('{1'b0,  3,  0, 0, 1'b0, "bounce_l1"});
    vecs.push_back('{1'b1,  3,  0, 0, 1'b0, "bounce_h1"});
    vecs.push_back('{1'b0,  3,  0, 0, 1'b0, "bounce_l2"});
    vecs.push_back('{1'b1,  3,  0, 0, 1'b0, "bounce_h2"});
    vecs.push_back('{1'b0,  3,  0, 0, 1'b0, "bounce_l3"});
    vecs.push_back('{1'b0, 20,  1, 0, 1'b1, "bounce_settle"});
    vecs.push_back('{1'b1, 20,  0, 0, 1'b0, "bounce_release"});
    vecs.push_back('{1'b0, 20,  1, 0, 1'b1, "rb_press"});
    vecs.push_back('{1'b1,  5,  0, 0, 1'b1, "rb_short_high"});
    vecs.push_back('{1'b0, 20,  0, 0, 1'b1, "rb_low_again"});
    vecs.push_back('{1'b1, 20,  0, 0, 1'b0, "rb_release"});
    vecs.push_back('{1'b0, 100, 1, 1, 1'b1, "long_hold"});
    vecs.push_back('{1'b1, 20,  0, 0, 1'b0, "long_release"});

    rst_n  = 1'b0;
    key_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("reset_flag",  int'(key_flag),  0);
    chk("reset_state", int'(key_state), 0);
    chk("reset_long",  int'(key_long),  0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    foreach (vecs[i]) begin
      key_in = vecs[i].key;
      n_flag = 0;
      n_long = 0;
      repeat (vecs[i].cycles) @(negedge sys_clk);
      chk({vecs[i].name, "_flags"}, n_flag, vecs[i].flags);
      chk({vecs[i].name, "_longs"}, n_long, vecs[i].longs);
      chk({vecs[i].name, "_state"}, int'(key_state), int'(vecs[i].state));
    end

    // Press latency, long-press timing, no repeat, release latency
    n_flag = 0;
    n_long = 0;
    key_in = 1'b0;
    edges_until(0, 40, idx);
    chk("press_latency_edge", idx, 13);
    edges_until(1, 80, idx);
    chk("long_after_down", idx + 1, 51);
    repeat (60) @(negedge sys_clk);
    chk("hold_state", int'(key_state), 1);
    key_in = 1'b1;
    edges_until(2, 40, idx);
    chk("release_latency_edge", idx, 13);
    @(negedge sys_clk);
    chk("hold_flags_total", n_flag, 1);
    chk("hold_longs_total", n_long, 1);

    // Reset in the middle of a held press, key still held at release
    key_in = 1'b0;
    #545;
    chk("pre_reset_state", int'(key_state), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_flag",  int'(key_flag),  0);
    chk("async_reset_state", int'(key_state), 0);
    chk("async_reset_long",  int'(key_long),  0);
    repeat (3) @(negedge sys_clk);
    chk("in_reset_state", int'(key_state), 0);
    rst_n = 1'b1;
    n_flag = 0;
    edges_until(0, 40, idx);
    chk("post_reset_latency_edge", idx, 13);
    @(negedge sys_clk);
    chk("post_reset_flags", n_flag, 1);
    chk("post_reset_state", int'(key_state), 1);
    key_in = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("final_state", int'(key_state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
